// File: rtl/image_proc_pkg.sv
// Shared constants, output bundle and arithmetic helpers for image_processor_core.
package image_proc_pkg;

    localparam int PIX_W = 8;
    localparam int DEFAULT_WIDTH = 128;

    localparam int LUMA_R = 77;
    localparam int LUMA_G = 150;
    localparam int LUMA_B = 29;
    localparam int LUMA_SHIFT = 8;
    localparam int ACC_W = 16;

    localparam int SUM_W = 12;
    localparam int DIV9_MUL = 7282;
    localparam int DIV9_SHIFT = 16;
    localparam int DIV9_PW = 26;

    typedef struct packed {
        logic [PIX_W-1:0] gray;
        logic [PIX_W-1:0] negative;
        logic             binary;
    } pix_out_t;

    function automatic logic [PIX_W-1:0] luma(
        input logic [PIX_W-1:0] r,
        input logic [PIX_W-1:0] g,
        input logic [PIX_W-1:0] b
    );
        logic [ACC_W-1:0] acc;
        acc = ACC_W'(LUMA_R * int'(r) + LUMA_G * int'(g) + LUMA_B * int'(b));
        return PIX_W'(acc >> LUMA_SHIFT);
    endfunction

    // 7282/2^16 over-estimates 1/9 by under 1/32768 per unit of s,
    // so the floor stays exact for every 12-bit window sum.
    function automatic logic [PIX_W-1:0] div9(input logic [SUM_W-1:0] s);
        logic [DIV9_PW-1:0] p;
        p = DIV9_PW'(s) * DIV9_PW'(DIV9_MUL);
        return PIX_W'(p >> DIV9_SHIFT);
    endfunction

endpackage

// File: rtl/image_processor_core_blur.sv
// 3x3 box blur over a raster gray stream using two circular line buffers.
module box_blur_3x3
    import image_proc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pixel,
    output logic [PIX_W-1:0] blurred
);

    localparam int PTR_W = $clog2(WIDTH);

    logic [PTR_W-1:0] ptr;
    logic [PIX_W-1:0] line1 [WIDTH];
    logic [PIX_W-1:0] line2 [WIDTH];
    logic [PIX_W-1:0] row0 [3];
    logic [PIX_W-1:0] row1 [3];
    logic [PIX_W-1:0] row2 [3];
    logic [SUM_W-1:0] sum;

    always_comb begin
        sum = '0;
        for (int i = 0; i < 3; i++) begin
            sum = sum + SUM_W'(row0[i]) + SUM_W'(row1[i]) + SUM_W'(row2[i]);
        end
    end

    // Line buffers are read and rewritten at the same slot each cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            blurred <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                line1[i] <= '0;
                line2[i] <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                row0[i] <= '0;
                row1[i] <= '0;
                row2[i] <= '0;
            end
        end else begin
            ptr <= (ptr == PTR_W'(WIDTH - 1)) ? '0 : ptr + 1'b1;
            line1[ptr] <= pixel;
            line2[ptr] <= line1[ptr];
            row0[0] <= pixel;
            row0[1] <= row0[0];
            row0[2] <= row0[1];
            row1[0] <= line1[ptr];
            row1[1] <= row1[0];
            row1[2] <= row1[1];
            row2[0] <= line2[ptr];
            row2[1] <= row2[0];
            row2[2] <= row2[1];
            blurred <= div9(sum);
        end
    end

endmodule

// File: rtl/image_processor_core.sv
// Per-pixel luma, negative, threshold and 3x3 blur for a raster RGB stream.
module image_processor_core
    import image_proc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] r,
    input  logic [PIX_W-1:0] g,
    input  logic [PIX_W-1:0] b,
    input  logic [PIX_W-1:0] threshold_val,
    output logic [PIX_W-1:0] gray,
    output logic [PIX_W-1:0] negative,
    output logic             binary,
    output logic [PIX_W-1:0] blurred
);

    logic [PIX_W-1:0] luma_c;
    pix_out_t         out_q;

    assign luma_c = luma(r, g, b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= '{
                gray:     luma_c,
                negative: ~luma_c,
                binary:   luma_c > threshold_val
            };
        end
    end

    assign gray = out_q.gray;
    assign negative = out_q.negative;
    assign binary = out_q.binary;

    box_blur_3x3 #(
        .WIDTH(WIDTH)
    ) u_blur (
        .clk(clk),
        .rst(rst),
        .pixel(out_q.gray),
        .blurred(blurred)
    );

endmodule

// File: tb/tb_image_processor_core.sv
// Scoreboard bench: one DUT at WIDTH=128 and one at WIDTH=8 share the input stream.
module tb_image_processor_core;

    localparam int WA = 128;
    localparam int WB = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] r = '0;
    logic [7:0] g = '0;
    logic [7:0] b = '0;
    logic [7:0] th = '0;

    logic [7:0] gray_a, negative_a, blurred_a;
    logic       binary_a;
    logic [7:0] gray_b, negative_b, blurred_b;
    logic       binary_b;

    int total = 0;
    int bad = 0;

    logic [7:0]  ghist[$];
    logic [16:0] q_pix[$];
    logic [7:0]  q_blur_a[$];
    logic [7:0]  q_blur_b[$];

    image_processor_core #(.WIDTH(WA)) dut_a (
        .clk(clk), .rst(rst), .r(r), .g(g), .b(b), .threshold_val(th),
        .gray(gray_a), .negative(negative_a), .binary(binary_a), .blurred(blurred_a)
    );

    image_processor_core #(.WIDTH(WB)) dut_b (
        .clk(clk), .rst(rst), .r(r), .g(g), .b(b), .threshold_val(th),
        .gray(gray_b), .negative(negative_b), .binary(binary_b), .blurred(blurred_b)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    function automatic logic [7:0] model_gray(input logic [7:0] rr, gg, bb);
        int acc;
        acc = 77 * int'(rr) + 150 * int'(gg) + 29 * int'(bb);
        return 8'(acc >> 8);
    endfunction

    function automatic logic [7:0] model_blur(input int w);
        int k, s, idx;
        k = ghist.size() - 1;
        s = 0;
        for (int l = 0; l < 3; l++)
            for (int c = 0; c < 3; c++) begin
                idx = k - c - l * w;
                if (idx >= 0) s += int'(ghist[idx]);
            end
        return 8'(s / 9);
    endfunction

    task automatic model_reset();
        ghist.delete();
        q_pix.delete();
        q_blur_a.delete();
        q_blur_b.delete();
        repeat (2) begin
            q_blur_a.push_back(8'd0);
            q_blur_b.push_back(8'd0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        r = '0; g = '0; b = '0; th = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives one pixel, pushes its expectations, and pops what the edge retires.
    task automatic step(
        input  logic [7:0] rr, gg, bb, tt,
        output logic [7:0] eg, en,
        output logic       eb,
        output logic [7:0] ea, ebb
    );
        logic [7:0] gv;
        r = rr; g = gg; b = bb; th = tt;
        gv = model_gray(rr, gg, bb);
        ghist.push_back(gv);
        q_pix.push_back({gv, 8'(255 - int'(gv)), gv > tt});
        q_blur_a.push_back(model_blur(WA));
        q_blur_b.push_back(model_blur(WB));
        @(posedge clk);
        #1;
        {eg, en, eb} = q_pix.pop_front();
        ea = q_blur_a.pop_front();
        ebb = q_blur_b.pop_front();
    endtask

    task automatic test_reset();
        logic [7:0] eg, en, ea, ebb;
        logic eb;
        do_reset();
        total++;
        if ({gray_a, negative_a, binary_a, blurred_a} !== 25'd0) begin
            bad++;
            $display("FAIL reset_a: got %h want 0",
                     {gray_a, negative_a, binary_a, blurred_a});
        end
        total++;
        if ({gray_b, negative_b, binary_b, blurred_b} !== 25'd0) begin
            bad++;
            $display("FAIL reset_b: got %h want 0",
                     {gray_b, negative_b, binary_b, blurred_b});
        end
        for (int i = 0; i < 3; i++) begin
            step(8'd0, 8'd0, 8'd0, 8'd0, eg, en, eb, ea, ebb);
            total++;
            if ({gray_a, binary_a, blurred_a, gray_b, blurred_b} !== 33'd0) begin
                bad++;
                $display("FAIL zero_stream[%0d]: got %h want 0", i,
                         {gray_a, binary_a, blurred_a, gray_b, blurred_b});
            end
        end
    endtask

    task automatic test_basic();
        logic [7:0] eg, en, ea, ebb;
        logic eb;
        step(8'd200, 8'd200, 8'd200, 8'd100, eg, en, eb, ea, ebb);
        total++;
        if ({gray_a, negative_a, binary_a} !== {8'd200, 8'd55, 1'b1}) begin
            bad++;
            $display("FAIL gray200: got %0d/%0d/%0d want 200/55/1",
                     gray_a, negative_a, binary_a);
        end
        step(8'd255, 8'd0, 8'd0, 8'd100, eg, en, eb, ea, ebb);
        total++;
        if ({gray_a, negative_a, binary_a} !== {8'd76, 8'd179, 1'b0}) begin
            bad++;
            $display("FAIL red255: got %0d/%0d/%0d want 76/179/0",
                     gray_a, negative_a, binary_a);
        end
        total++;
        if ({gray_b, negative_b, binary_b} !== {eg, en, eb}) begin
            bad++;
            $display("FAIL red255_b: got %0d/%0d/%0d want %0d/%0d/%0d",
                     gray_b, negative_b, binary_b, eg, en, eb);
        end
    endtask

    task automatic test_threshold();
        logic [7:0] eg, en, ea, ebb;
        logic eb;
        step(8'd100, 8'd100, 8'd100, 8'd100, eg, en, eb, ea, ebb);
        total++;
        if ({gray_a, binary_a} !== {8'd100, 1'b0}) begin
            bad++;
            $display("FAIL thr_equal: got gray=%0d bin=%0d want 100/0",
                     gray_a, binary_a);
        end
        step(8'd100, 8'd100, 8'd100, 8'd99, eg, en, eb, ea, ebb);
        total++;
        if ({gray_a, binary_a} !== {8'd100, 1'b1}) begin
            bad++;
            $display("FAIL thr_below: got gray=%0d bin=%0d want 100/1",
                     gray_a, binary_a);
        end
    endtask

    task automatic test_blur_const90();
        logic [7:0] eg, en, ea, ebb, want;
        logic eb;
        int k;
        do_reset();
        for (int j = 0; j < 2 * WA + 7; j++) begin
            step(8'd90, 8'd90, 8'd90, 8'd50, eg, en, eb, ea, ebb);
            k = j - 2;
            if (k == 0) want = 8'd10;
            else if (k >= 2 * WA + 2) want = 8'd90;
            else want = ea;
            total++;
            if (blurred_a !== want || blurred_b !== ebb) begin
                bad++;
                $display("FAIL blur90[%0d]: got %0d/%0d want %0d/%0d",
                         j, blurred_a, blurred_b, want, ebb);
            end
        end
    endtask

    task automatic test_blur_255();
        logic [7:0] eg, en, ea, ebb;
        logic eb;
        do_reset();
        for (int j = 0; j < 2 * WA + 5; j++) begin
            step(8'd255, 8'd255, 8'd255, 8'd0, eg, en, eb, ea, ebb);
            total++;
            if (blurred_b !== ebb) begin
                bad++;
                $display("FAIL blur255_b[%0d]: got %0d want %0d", j, blurred_b, ebb);
            end
        end
        total++;
        if (blurred_a !== 8'd255) begin
            bad++;
            $display("FAIL blur255: got %0d want 255", blurred_a);
        end
    endtask

    task automatic test_impulse();
        logic [7:0] eg, en, ea, ebb, want, v;
        logic eb;
        int d, hits;
        do_reset();
        hits = 0;
        for (int j = 0; j < 2 * WA + 14; j++) begin
            v = (j == 5) ? 8'd180 : 8'd0;
            step(v, v, v, 8'd0, eg, en, eb, ea, ebb);
            d = j - 2 - 5;
            if ((d >= 0 && d <= 2) || (d >= WA && d <= WA + 2) ||
                (d >= 2 * WA && d <= 2 * WA + 2))
                want = 8'd20;
            else
                want = 8'd0;
            if (blurred_a == 8'd20) hits++;
            total++;
            if (blurred_a !== want || blurred_b !== ebb) begin
                bad++;
                $display("FAIL impulse[%0d]: got %0d/%0d want %0d/%0d",
                         j, blurred_a, blurred_b, want, ebb);
            end
        end
        total++;
        if (hits !== 9) begin
            bad++;
            $display("FAIL impulse_hits: got %0d want 9", hits);
        end
    endtask

    task automatic test_random();
        logic [7:0] eg, en, ea, ebb;
        logic eb;
        do_reset();
        for (int j = 0; j < 300; j++) begin
            step(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 eg, en, eb, ea, ebb);
            total++;
            if ({gray_a, negative_a, binary_a, blurred_a} !== {eg, en, eb, ea}) begin
                bad++;
                $display("FAIL rand_a[%0d]: got %h want %h", j,
                         {gray_a, negative_a, binary_a, blurred_a}, {eg, en, eb, ea});
            end
            total++;
            if ({gray_b, negative_b, binary_b, blurred_b} !== {eg, en, eb, ebb}) begin
                bad++;
                $display("FAIL rand_b[%0d]: got %h want %h", j,
                         {gray_b, negative_b, binary_b, blurred_b}, {eg, en, eb, ebb});
            end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] eg, en, ea, ebb;
        logic eb;
        do_reset();
        for (int j = 0; j < 20; j++)
            step(8'd200, 8'd100, 8'd50, 8'd10, eg, en, eb, ea, ebb);
        total++;
        if ({gray_a, blurred_a} !== {eg, ea}) begin
            bad++;
            $display("FAIL pre_reset: got %0d/%0d want %0d/%0d",
                     gray_a, blurred_a, eg, ea);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({gray_a, negative_a, binary_a, blurred_a,
             gray_b, negative_b, binary_b, blurred_b} !== 50'd0) begin
            bad++;
            $display("FAIL async_reset: got %h/%h want 0",
                     {gray_a, negative_a, binary_a, blurred_a},
                     {gray_b, negative_b, binary_b, blurred_b});
        end
        do_reset();
        step(8'd0, 8'd0, 8'd0, 8'd0, eg, en, eb, ea, ebb);
        total++;
        if ({blurred_a, blurred_b} !== 16'd0) begin
            bad++;
            $display("FAIL post_reset_blur: got %0d/%0d want 0/0",
                     blurred_a, blurred_b);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_threshold();
        test_blur_const90();
        test_blur_255();
        test_impulse();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
